pipe_writeback_hazard: RTL and testbench
========================================

PIPE_WRITEBACK_HAZARD -- requirements
Module: pipe_writeback_hazard

Interface
REQ-001 Parameters SHALL be: XLEN, default 32, datapath width; REGW, default 5, register-index width.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 = in reset.
- valid_m  in  1  MEM-stage instruction valid.
- reg_write_m  in  1  MEM-stage register-write enable.
- result_src_m  in  2  result select: 00 ALU, 01 load data, 10 PC+4, 11 reserved.
- alu_result_m  in  XLEN  MEM-stage ALU result.
- read_data_m  in  XLEN  data-memory read data.
- pc_plus_4_m  in  XLEN  MEM-stage PC+4.
- rd_m  in  REGW  MEM-stage destination register.
- rs1_e, rs2_e  in  REGW each  EX-stage source registers.
- rd_e  in  REGW  EX-stage destination register.
- result_src_e  in  2  EX-stage result select; 01 marks a load.
- rs1_d, rs2_d  in  REGW each  decode-stage source registers.
- result_w  out  XLEN  selected writeback data.
- rd_w  out  REGW  writeback destination register.
- reg_write_w  out  1  register-file write enable.
- forward_a_e, forward_b_e  out  2 each  EX operand select: 00 regfile, 10 MEM, 01 WB.
- stall_f, stall_d, flush_e  out  1 each  load-use hazard controls.
- stall_count  out  32  load-use stall counter; present only with HAZARD_PERF_EN.

Function
REQ-003 On every rising clk edge with reset high, the block SHALL capture valid_m, reg_write_m, result_src_m, alu_result_m, read_data_m, pc_plus_4_m and rd_m into MEM/WB registers; latency 1 cycle.
REQ-004 reg_write_w SHALL equal registered reg_write_m AND registered valid_m.
REQ-005 result_w SHALL be combinational from the registers: 00 -> ALU result, 01 -> read data, 10 -> PC+4, 11 -> all zeros.
REQ-006 rd_w SHALL equal the registered rd_m.
REQ-007 forward_a_e SHALL be 10 when reg_write_m and valid_m and rd_m != 0 and rd_m == rs1_e; else 01 when reg_write_w and rd_w != 0 and rd_w == rs1_e; else 00.
REQ-008 forward_b_e SHALL follow REQ-007 using rs2_e.
REQ-009 When MEM and WB both match, MEM SHALL win.
REQ-010 Register x0 SHALL never be forwarded.
REQ-011 A load-use hazard is defined as: result_src_e == 01 and rd_e != 0 and (rd_e == rs1_d or rd_e == rs2_d).
REQ-012 On a load-use hazard, stall_f, stall_d and flush_e SHALL assert combinationally in that same cycle.
REQ-013 After one stall the flushed EX bubble removes the hazard, so stalls SHALL last exactly one cycle per load-use pair.
REQ-014 Forwarding SHALL NOT be gated by the stall outputs.
REQ-015 Forwarding and hazard outputs SHALL be purely combinational.

Reset
REQ-016 While reset is low, every MEM/WB register SHALL clear to 0 immediately, independent of clk.
REQ-017 During reset, result_w, rd_w and reg_write_w SHALL read 0.
REQ-018 stall_count SHALL clear to 0 when reset goes low.
REQ-019 If reset asserts in the middle of an operation, no writeback SHALL occur, and the first capture SHALL be on the first rising edge after reset returns high.

Configuration
REQ-020 With macro HAZARD_PERF_EN defined:
- stall_count port exists.
- stall_count increments by 1 on each rising edge where stall_d is 1.
- stall_count saturates at 0xFFFFFFFF.
REQ-021 Without HAZARD_PERF_EN, the stall_count port and its register SHALL be absent; all other behaviour is unchanged.

Verification
REQ-022 Writeback capture: valid_m=1, reg_write_m=1, result_src_m=01, read_data_m=0xDEADBEEF, rd_m=7 -> one edge later result_w=0xDEADBEEF, rd_w=7, reg_write_w=1.
REQ-023 Forward priority: rd_m=5 (writing, valid), rd_w=5 (writing), rs1_e=5, rs2_e=6 -> forward_a_e=10, forward_b_e=00; then drop reg_write_m -> forward_a_e=01.
REQ-024 x0 and invalid instructions: rd_m=0 with rs1_e=0 -> forward_a_e=00; valid_m=0 with reg_write_m=1 -> reg_write_w=0 after the edge.
REQ-025 Load-use: result_src_e=01, rd_e=3, rs2_d=3 -> stall_f=stall_d=flush_e=1; then rd_e=0 -> all three deassert; with HAZARD_PERF_EN, stall_count reads 1.
REQ-026 Asynchronous reset: pull reset low between edges while reg_write_w=1, result_w=0x1234 -> outputs read 0 before the next edge; release reset -> capture resumes on the next edge.
REQ-027 Counter saturation (HAZARD_PERF_EN): preload stall_count to 0xFFFFFFFE, apply 3 stall cycles -> stall_count=0xFFFFFFFF.

Source files
------------

// File: rtl/pipe_writeback_hazard.sv
// MEM/WB writeback register plus combinational forwarding and load-use hazard detection.
// Optional macro HAZARD_PERF_EN adds a saturating load-use stall counter (stall_count).
module pipe_writeback_hazard #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_m,
  input  logic            reg_write_m,
  input  logic [1:0]      result_src_m,
  input  logic [XLEN-1:0] alu_result_m,
  input  logic [XLEN-1:0] read_data_m,
  input  logic [XLEN-1:0] pc_plus_4_m,
  input  logic [REGW-1:0] rd_m,
  input  logic [REGW-1:0] rs1_e,
  input  logic [REGW-1:0] rs2_e,
  input  logic [REGW-1:0] rd_e,
  input  logic [1:0]      result_src_e,
  input  logic [REGW-1:0] rs1_d,
  input  logic [REGW-1:0] rs2_d,
  output logic [XLEN-1:0] result_w,
  output logic [REGW-1:0] rd_w,
  output logic            reg_write_w,
  output logic [1:0]      forward_a_e,
  output logic [1:0]      forward_b_e,
  output logic            stall_f,
  output logic            stall_d,
  output logic            flush_e
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]     stall_count
`endif
);

  logic            valid_q, valid_d;
  logic            reg_write_q, reg_write_d;
  logic [1:0]      result_src_q, result_src_d;
  logic [XLEN-1:0] alu_result_q, alu_result_d;
  logic [XLEN-1:0] read_data_q, read_data_d;
  logic [XLEN-1:0] pc_plus_4_q, pc_plus_4_d;
  logic [REGW-1:0] rd_q, rd_d;
  logic            mem_writes;
  logic            load_use;

  assign valid_d      = valid_m;
  assign reg_write_d  = reg_write_m;
  assign result_src_d = result_src_m;
  assign alu_result_d = alu_result_m;
  assign read_data_d  = read_data_m;
  assign pc_plus_4_d  = pc_plus_4_m;
  assign rd_d         = rd_m;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      result_src_q <= 2'b00;
      alu_result_q <= '0;
      read_data_q  <= '0;
      pc_plus_4_q  <= '0;
      rd_q         <= '0;
    end else begin
      valid_q      <= valid_d;
      reg_write_q  <= reg_write_d;
      result_src_q <= result_src_d;
      alu_result_q <= alu_result_d;
      read_data_q  <= read_data_d;
      pc_plus_4_q  <= pc_plus_4_d;
      rd_q         <= rd_d;
    end
  end

  always_comb begin
    result_w = '0;
    case (result_src_q)
      2'b00:   result_w = alu_result_q;
      2'b01:   result_w = read_data_q;
      2'b10:   result_w = pc_plus_4_q;
      default: result_w = '0;
    endcase
  end

  assign rd_w        = rd_q;
  assign reg_write_w = reg_write_q & valid_q;

  // MEM is checked first so the younger result wins; x0 is never forwarded.
  assign mem_writes = reg_write_m & valid_m & (rd_m != '0);

  always_comb begin
    forward_a_e = 2'b00;
    forward_b_e = 2'b00;
    if (mem_writes && (rd_m == rs1_e))
      forward_a_e = 2'b10;
    else if (reg_write_w && (rd_w != '0) && (rd_w == rs1_e))
      forward_a_e = 2'b01;
    if (mem_writes && (rd_m == rs2_e))
      forward_b_e = 2'b10;
    else if (reg_write_w && (rd_w != '0) && (rd_w == rs2_e))
      forward_b_e = 2'b01;
  end

  assign load_use = (result_src_e == 2'b01) && (rd_e != '0) &&
                    ((rd_e == rs1_d) || (rd_e == rs2_d));
  assign stall_f  = load_use;
  assign stall_d  = load_use;
  assign flush_e  = load_use;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_count_q, stall_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall_d && (stall_count_q != 32'hFFFF_FFFF))
      stall_count_d = stall_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_count_q <= '0;
    else        stall_count_q <= stall_count_d;
  end

  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_pipe_writeback_hazard.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_pipe_writeback_hazard;
  localparam int XLEN = 32;
  localparam int REGW = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic            valid_m, reg_write_m;
  logic [1:0]      result_src_m, result_src_e;
  logic [XLEN-1:0] alu_result_m, read_data_m, pc_plus_4_m;
  logic [REGW-1:0] rd_m, rs1_e, rs2_e, rd_e, rs1_d, rs2_d;
  logic [XLEN-1:0] result_w;
  logic [REGW-1:0] rd_w;
  logic            reg_write_w, stall_f, stall_d, flush_e;
  logic [1:0]      forward_a_e, forward_b_e;
`ifdef HAZARD_PERF_EN
  logic [31:0]     stall_count;
`endif

  always #5 clk = ~clk;

  pipe_writeback_hazard #(.XLEN(XLEN), .REGW(REGW)) dut (
    .clk(clk), .reset(reset), .valid_m(valid_m), .reg_write_m(reg_write_m),
    .result_src_m(result_src_m), .alu_result_m(alu_result_m), .read_data_m(read_data_m),
    .pc_plus_4_m(pc_plus_4_m), .rd_m(rd_m), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .result_src_e(result_src_e), .rs1_d(rs1_d), .rs2_d(rs2_d), .result_w(result_w),
    .rd_w(rd_w), .reg_write_w(reg_write_w), .forward_a_e(forward_a_e),
    .forward_b_e(forward_b_e), .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e)
`ifdef HAZARD_PERF_EN
    , .stall_count(stall_count)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Model: the instruction last accepted from MEM (what WB should show) and the stall tally.
  logic            wb_vld, wb_rw;
  logic [1:0]      wb_src;
  logic [XLEN-1:0] wb_val [4];
  logic [REGW-1:0] wb_rd;
  longint          model_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    wb_vld = 0; wb_rw = 0; wb_src = 0; wb_rd = 0;
    for (int i = 0; i < 4; i++) wb_val[i] = '0;
    model_cnt = 0;
  endtask

  function automatic logic [1:0] exp_fwd(input logic [REGW-1:0] rs);
    if (reg_write_m && valid_m && rd_m != 0 && rd_m == rs) return 2'b10;
    if (wb_rw && wb_vld && wb_rd != 0 && wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic hazard();
    return (result_src_e == 2'b01) && (rd_e != 0) && (rd_e == rs1_d || rd_e == rs2_d);
  endfunction

  task automatic check_all();
    chk("result_w", result_w, wb_val[wb_src]);
    chk("rd_w", 32'(rd_w), 32'(wb_rd));
    chk("reg_write_w", 32'(reg_write_w), 32'(wb_rw & wb_vld));
    chk("forward_a_e", 32'(forward_a_e), 32'(exp_fwd(rs1_e)));
    chk("forward_b_e", 32'(forward_b_e), 32'(exp_fwd(rs2_e)));
    chk("stall_f", 32'(stall_f), 32'(hazard()));
    chk("stall_d", 32'(stall_d), 32'(hazard()));
    chk("flush_e", 32'(flush_e), 32'(hazard()));
`ifdef HAZARD_PERF_EN
    chk("stall_count", stall_count, 32'(model_cnt));
`endif
  endtask

  // Advance one clock edge; the model captures whatever MEM presented at that edge.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      wb_vld = valid_m; wb_rw = reg_write_m; wb_src = result_src_m; wb_rd = rd_m;
      wb_val[0] = alu_result_m; wb_val[1] = read_data_m; wb_val[2] = pc_plus_4_m; wb_val[3] = '0;
      if (hazard() && model_cnt < 64'hFFFF_FFFF) model_cnt++;
    end
    #1;
  endtask

  task automatic drive_zero();
    valid_m = 0; reg_write_m = 0; result_src_m = 0; alu_result_m = 0; read_data_m = 0;
    pc_plus_4_m = 0; rd_m = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; result_src_e = 0;
    rs1_d = 0; rs2_d = 0;
  endtask

  task automatic drive_random();
    valid_m = 1'($urandom); reg_write_m = 1'($urandom); result_src_m = 2'($urandom);
    alu_result_m = $urandom; read_data_m = $urandom; pc_plus_4_m = $urandom;
    rd_m = 5'($urandom_range(0, 7)); rs1_e = 5'($urandom_range(0, 7));
    rs2_e = 5'($urandom_range(0, 7)); rd_e = 5'($urandom_range(0, 7));
    result_src_e = 2'($urandom); rs1_d = 5'($urandom_range(0, 7));
    rs2_d = 5'($urandom_range(0, 7));
  endtask

  initial begin
    reset = 1'b0;
    drive_zero();
    model_clear();
    #3;
    chk("reset_result_w", result_w, 32'h0);
    chk("reset_rd_w", 32'(rd_w), 32'h0);
    chk("reset_reg_write_w", 32'(reg_write_w), 32'h0);
    check_all();
    @(negedge clk); reset = 1'b1;

    // Load data capture
    valid_m = 1; reg_write_m = 1; result_src_m = 2'b01; read_data_m = 32'hDEADBEEF; rd_m = 7;
    alu_result_m = 32'h1111; pc_plus_4_m = 32'h2222;
    tick();
    chk("wb_load_result", result_w, 32'hDEADBEEF);
    chk("wb_load_rd", 32'(rd_w), 32'd7);
    chk("wb_load_we", 32'(reg_write_w), 32'd1);
    check_all();

    // Forward priority: MEM beats WB
    result_src_m = 2'b00; alu_result_m = 32'h55; rd_m = 5;
    tick();
    rs1_e = 5; rs2_e = 6; #1;
    chk("fwd_prio_a", 32'(forward_a_e), 32'b10);
    chk("fwd_prio_b", 32'(forward_b_e), 32'b00);
    check_all();
    reg_write_m = 0; #1;
    chk("fwd_wb_a", 32'(forward_a_e), 32'b01);
    check_all();

    // x0 never forwarded, invalid instruction never writes
    reg_write_m = 1; rd_m = 0; rs1_e = 0; #1;
    chk("fwd_x0_a", 32'(forward_a_e), 32'b00);
    valid_m = 0; rd_m = 9;
    tick();
    chk("invalid_no_write", 32'(reg_write_w), 32'd0);
    check_all();

    // Load-use stall, one cycle
    valid_m = 1; result_src_e = 2'b01; rd_e = 3; rs1_d = 1; rs2_d = 3; #1;
    chk("lu_stall_f", 32'(stall_f), 32'd1);
    chk("lu_stall_d", 32'(stall_d), 32'd1);
    chk("lu_flush_e", 32'(flush_e), 32'd1);
    tick();
    rd_e = 0; #1;
    chk("lu_clear", 32'({stall_f, stall_d, flush_e}), 32'd0);
`ifdef HAZARD_PERF_EN
    chk("lu_count", stall_count, 32'd1);
`endif
    check_all();

    // Asynchronous reset between edges, then resume
    valid_m = 1; reg_write_m = 1; result_src_m = 2'b00; alu_result_m = 32'h1234; rd_m = 9;
    tick();
    chk("pre_reset_result", result_w, 32'h1234);
    reset = 0; model_clear(); #1;
    chk("async_result", result_w, 32'h0);
    chk("async_we", 32'(reg_write_w), 32'h0);
    chk("async_rd", 32'(rd_w), 32'h0);
    alu_result_m = 32'h4321; rd_m = 10;
    tick();
    check_all();
    @(negedge clk); reset = 1;
    chk("release_no_capture", result_w, 32'h0);
    tick();
    chk("resume_result", result_w, 32'h4321);
    chk("resume_rd", 32'(rd_w), 32'd10);
    check_all();

    // Randomized traffic with occasional mid-cycle reset pulses
    for (int n = 0; n < 400; n++) begin
      drive_random();
      @(negedge clk);
      check_all();
      if ($urandom_range(0, 49) == 0) begin
        reset = 0; model_clear(); #1;
        check_all();
        tick();
        check_all();
        @(negedge clk); reset = 1;
      end
      tick();
    end

`ifdef HAZARD_PERF_EN
    // Saturation from a preloaded counter
    drive_zero();
    @(negedge clk);
    dut.stall_count_q = 32'hFFFF_FFFE;
    model_cnt = 64'hFFFF_FFFE;
    result_src_e = 2'b01; rd_e = 4; rs1_d = 4;
    for (int k = 0; k < 3; k++) tick();
    chk("count_saturate", stall_count, 32'hFFFF_FFFF);
    check_all();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end
endmodule
